// File: rtl/gpio_poll_ctrl.sv
// rtl/gpio_poll_ctrl.sv - AXI4-Lite master that polls GPIO switches, debounces them and drives the LEDs
// Timer-driven poll: read switch word, debounce, optionally write LED pattern, wait for the write response.
module gpio_poll_ctrl #(
  parameter int unsigned POLL_CYCLES = 1000,
  parameter int unsigned DEBOUNCE    = 3,
  parameter logic [31:0] SW_ADDR     = 32'h0,
  parameter logic [31:0] LED_ADDR    = 32'h4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic        b_ready,
  input  logic        b_valid,
  input  logic [1:0]  b_response,
  output logic [3:0]  sw_stable,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int WW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_CYCLES - 1);
  localparam logic [DW-1:0] DBC_MAX      = DW'(DEBOUNCE);
  localparam logic [WW-1:0] WAIT_MAX     = WW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cand_q, cand_d;
  logic [DW-1:0] dbc_q, dbc_d;
  logic [3:0]    sw_stable_q, sw_stable_d;
  logic [7:0]    led_cnt_q, led_cnt_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          aw_hs, w_hs, changed;
  logic [3:0]    s;
  logic          unused_rdata;

  assign unused_rdata = ^axi_rdata[31:4];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cand_d      = cand_q;
    dbc_d       = dbc_q;
    sw_stable_d = sw_stable_q;
    led_cnt_d   = led_cnt_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wait_d      = wait_q;
    err_d       = err_q;
    changed     = 1'b0;
    s           = axi_rdata[3:0];
    aw_hs       = awvalid_q & axi_awready;
    w_hs        = wvalid_q & axi_wready;

    case (state_q)
      IDLE: begin
        if (enable) begin
          if (timer_q == '0) begin
            state_d = RD_A;
            timer_d = TIMER_RELOAD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      RD_A: if (axi_arready) state_d = RD_D;
      RD_D: begin
        if (axi_rvalid) begin
          if (s == cand_q) begin
            dbc_d = (dbc_q == DBC_MAX) ? dbc_q : dbc_q + DW'(1);
          end else begin
            cand_d = s;
            dbc_d  = DW'(1);
          end
          changed = (dbc_d == DBC_MAX) && (cand_d != sw_stable_q);
          if (changed) sw_stable_d = cand_d;
          // Counter mode writes on every poll, otherwise only on a debounced change.
          if (changed || sw_stable_d[3]) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = sw_stable_d[3] ? led_cnt_q : {sw_stable_d, sw_stable_d};
          end else begin
            state_d = IDLE;
          end
        end
      end
      WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_d = WR_B;
      end
      WR_B: begin
        if (b_valid) begin
          if (b_response != 2'b00) err_d = 1'b1;
          if (sw_stable_q[3]) led_cnt_d = led_cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Wait counter saturates; err fires once a state has stalled more than TIMEOUT cycles.
    if (state_q == IDLE || state_d != state_q) begin
      wait_d = '0;
    end else if (wait_q >= WAIT_MAX) begin
      err_d = 1'b1;
    end else begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= TIMER_RELOAD;
      cand_q      <= '0;
      dbc_q       <= '0;
      sw_stable_q <= '0;
      led_cnt_q   <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cand_q      <= cand_d;
      dbc_q       <= dbc_d;
      sw_stable_q <= sw_stable_d;
      led_cnt_q   <= led_cnt_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
    end
  end

  assign axi_araddr  = SW_ADDR;
  assign axi_awaddr  = LED_ADDR;
  assign axi_wdata   = {24'd0, wdata_q};
  assign axi_arvalid = (state_q == RD_A);
  assign axi_rready  = (state_q == RD_D);
  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign b_ready     = (state_q == WR_B);
  assign sw_stable   = sw_stable_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule
